lcd_hd44780_responder: RTL and testbench

Synthesizable model of the HD44780 controller side of the 4-bit LCD bus (DB7..DB4, RS, RW, E) driven by the team's LCD init/write FSMs. It samples E falling edges, assembles nibbles into instructions and data, and keeps the instruction-decode state, address counter (AC), an 80-byte DDRAM and busy timing. It answers busy-flag and data reads. Used as an on-board loopback target and as the scoreboard-grade DUT partner in bench runs.

---
 rtl/lcd_hd44780_pkg.sv | 46 ++++
 rtl/lcd_hd44780_responder_if.sv | 12 +
 rtl/lcd_bus_sync.sv | 42 ++++
 rtl/lcd_hd44780_responder.sv | 172 +++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_hd44780_pkg.sv
// Shared constants, enums and address helpers for the HD44780 bus responder.
package lcd_hd44780_pkg;

  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  localparam logic [6:0] AC_L0_END = 7'h27;
  localparam logic [6:0] AC_L1_BEG = 7'h40;
  localparam logic [6:0] AC_L1_END = 7'h67;
  localparam logic [6:0] AC_1L_END = 7'h4F;

  localparam logic [7:0] CHAR_BLANK   = 8'h20;
  localparam int         DDRAM_SIZE   = 80;
  localparam int         CYC_EXEC_DEF = 4000;
  localparam int         CYC_LONG_DEF = 152000;

  typedef enum logic {PH_UPPER, PH_LOWER} phase_t;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR_FILL, S_BUSY} state_t;

  // {valid, index}; line 2 of a two-line panel lands at indices 40..79
  function automatic logic [7:0] ddram_index(input logic [6:0] a, input logic tl);
    if (tl) begin
      if (a <= AC_L0_END) return {1'b1, a};
      if (a >= AC_L1_BEG && a <= AC_L1_END) return {1'b1, a - AC_L1_BEG + 7'd40};
      return 8'h00;
    end
    if (a <= AC_1L_END) return {1'b1, a};
    return 8'h00;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc, input logic tl);
    if (tl) begin
      if (inc) return (a == AC_L0_END) ? AC_L1_BEG : (a == AC_L1_END) ? 7'h00 : a + 7'd1;
      return (a == AC_L1_BEG) ? AC_L0_END : (a == 7'h00) ? AC_L1_END : a - 7'd1;
    end
    if (inc) return (a == AC_1L_END) ? 7'h00 : a + 7'd1;
    return (a == 7'h00) ? AC_1L_END : a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// HD44780 parallel bus as seen between the initiator (master) and the responder (slave).
interface lcd_hd44780_responder_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_db_in;
  logic [3:0] lcd_db_out;
  logic       lcd_db_oe;

  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_db_in, input lcd_db_out, lcd_db_oe);
  modport slave  (input lcd_e, lcd_rs, lcd_rw, lcd_db_in, output lcd_db_out, lcd_db_oe);
endinterface

// File: rtl/lcd_bus_sync.sv
// Synchronizes the LCD bus into clk and flags E edges; *_h hold RS/RW/DB from the last E-high cycle.
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       e,
  input  logic       rs,
  input  logic       rw,
  input  logic [3:0] db,
  output logic       e_s,
  output logic       rs_s,
  output logic       rw_s,
  output logic       rs_h,
  output logic       rw_h,
  output logic [3:0] db_h,
  output logic       e_rise,
  output logic       e_fall
);
  logic [6:0] stg [SYNC_STAGES];
  logic [3:0] db_s;
  logic       e_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= '0;
      e_d  <= 1'b0;
      rs_h <= 1'b0;
      rw_h <= 1'b0;
      db_h <= 4'h0;
    end else begin
      stg[0] <= {e, rs, rw, db};
      for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
      e_d <= e_s;
      if (e_s) {rs_h, rw_h, db_h} <= {rs_s, rw_s, db_s};
    end
  end

  assign {e_s, rs_s, rw_s, db_s} = stg[SYNC_STAGES-1];
  assign e_rise = e_s & ~e_d;
  assign e_fall = ~e_s & e_d;
endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780 responder: assembles E-fall transfers, executes instructions, owns AC, DDRAM and BF.
// state | meaning: S_IDLE wait | S_EXEC apply latched byte | S_CLEAR_FILL blank DDRAM | S_BUSY hold BF
module lcd_hd44780_responder
  import lcd_hd44780_pkg::*;
#(
  parameter int CYC_EXEC    = CYC_EXEC_DEF,
  parameter int CYC_LONG    = CYC_LONG_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nrst,
  lcd_hd44780_responder_if.slave bus,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       four_bit_mode,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cmd_strobe,
  output logic       protocol_err
);
  localparam int CNT_W = $clog2(CYC_LONG + 1);

  logic             e_s, rs_s, rw_s, rs_h, rw_h, e_rise, e_fall, oe;
  logic [3:0]       db_h, up_nib, rd_nib;
  logic             up_rs, up_rw, ex_rs, ex_rw, i_d, cgram_sel;
  state_t           state, state_nx;
  phase_t           phase, phase_nx;
  logic [7:0]       ex_byte, new_byte, snap, live_snap, ac_cell, ac_idx;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       fill_idx;
  logic [7:0]       ddram [DDRAM_SIZE];
  logic             acc_exec, acc_upper, drop, bf_rd, is_long, is_clear;
  logic             do_exec, fill_we, wr_we;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .nrst(nrst), .e(bus.lcd_e), .rs(bus.lcd_rs), .rw(bus.lcd_rw), .db(bus.lcd_db_in),
    .e_s(e_s), .rs_s(rs_s), .rw_s(rw_s), .rs_h(rs_h), .rw_h(rw_h), .db_h(db_h),
    .e_rise(e_rise), .e_fall(e_fall)
  );

  assign busy     = (cnt != '0);
  assign bf_rd    = ~rs_h & rw_h;
  assign is_long  = ~rs_h && (new_byte[7:2] == 6'd0) && (new_byte[1:0] != 2'd0);
  assign is_clear = ~ex_rs && (ex_byte == OP_CLEAR);
  assign ac_idx   = ddram_index(ac, two_line);
  assign ac_cell  = ac_idx[7] ? ddram[ac_idx[6:0]] : CHAR_BLANK;
  assign live_snap = rs_s ? ac_cell : {busy, ac};
  assign wr_we    = do_exec && ex_rs && !ex_rw && !cgram_sel && ac_idx[7];
  assign protocol_err = drop;

  // Bus transfer acceptance; BF reads bypass the busy check
  always_comb begin
    acc_exec  = 1'b0;
    acc_upper = 1'b0;
    drop      = 1'b0;
    phase_nx  = phase;
    new_byte  = {db_h, 4'h0};
    if (e_fall) begin
      if (!four_bit_mode) begin
        if (!bf_rd) begin
          if (busy) drop = 1'b1;
          else      acc_exec = 1'b1;
        end
      end else if (phase == PH_UPPER) begin
        if (!rw_h && busy) drop = 1'b1;
        else begin
          acc_upper = 1'b1;
          phase_nx  = PH_LOWER;
        end
      end else begin
        phase_nx = PH_UPPER;
        new_byte = {up_nib, db_h};
        if (rs_h != up_rs || rw_h != up_rw) drop = 1'b1;
        else if (!bf_rd) begin
          if (busy) drop = 1'b1;
          else      acc_exec = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx   = state;
    cmd_strobe = 1'b0;
    do_exec    = 1'b0;
    fill_we    = 1'b0;
    case (state)
      S_IDLE:       if (acc_exec) state_nx = S_EXEC;
      S_EXEC: begin
        cmd_strobe = 1'b1;
        do_exec    = 1'b1;
        state_nx   = is_clear ? S_CLEAR_FILL : S_BUSY;
      end
      S_CLEAR_FILL: begin
        fill_we = 1'b1;
        if (fill_idx == 7'(DDRAM_SIZE - 1)) state_nx = S_BUSY;
      end
      S_BUSY:       if (!busy) state_nx = acc_exec ? S_EXEC : S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;  phase <= PH_UPPER;
      up_nib <= 4'h0;   up_rs <= 1'b0;  up_rw <= 1'b0;
      ex_byte <= 8'h00; ex_rs <= 1'b0;  ex_rw <= 1'b0;
      cnt <= '0;        i_d <= 1'b1;    cgram_sel <= 1'b0;
      fill_idx <= 7'd0; snap <= 8'h00;  ac <= 7'd0;
      disp_on <= 1'b0;  cursor_on <= 1'b0; blink_on <= 1'b0;
      two_line <= 1'b0; four_bit_mode <= 1'b0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      if (acc_upper) {up_nib, up_rs, up_rw} <= {db_h, rs_h, rw_h};
      if (acc_exec) begin
        {ex_byte, ex_rs, ex_rw} <= {new_byte, rs_h, rw_h};
        cnt <= is_long ? CNT_W'(CYC_LONG) : CNT_W'(CYC_EXEC);
      end else if (busy) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (e_rise && rw_s && phase == PH_UPPER) snap <= live_snap;
      if (fill_we) fill_idx <= fill_idx + 7'd1;
      if (do_exec) begin
        if (ex_rs) ac <= ac_step(ac, i_d, two_line);
        else if (|(ex_byte & OP_DDRAM)) begin
          ac <= ex_byte[6:0];
          cgram_sel <= 1'b0;
        end else if (|(ex_byte & OP_CGRAM)) cgram_sel <= 1'b1;
        else if (|(ex_byte & OP_FUNC)) begin
          // before the DL=0 switch only DL is honoured; N is latched once in 4-bit mode
          if (four_bit_mode) begin
            two_line <= ex_byte[3];
            if (ex_byte[4]) four_bit_mode <= 1'b0;
          end else if (!ex_byte[4]) four_bit_mode <= 1'b1;
        end else if (|(ex_byte & OP_SHIFT)) begin
          if (!ex_byte[3]) ac <= ac_step(ac, ex_byte[2], two_line);
        end else if (|(ex_byte & OP_DISPLAY)) {disp_on, cursor_on, blink_on} <= ex_byte[2:0];
        else if (|(ex_byte & OP_ENTRY)) i_d <= ex_byte[1];
        else if (|(ex_byte & OP_HOME)) ac <= 7'd0;
        else if (|(ex_byte & OP_CLEAR)) begin
          ac <= 7'd0;
          i_d <= 1'b1;
          fill_idx <= 7'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)    ddram[fill_idx] <= CHAR_BLANK;
    else if (wr_we) ddram[ac_idx[6:0]] <= ex_byte;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) rd_data <= CHAR_BLANK;
    else       rd_data <= (rd_addr < 7'(DDRAM_SIZE)) ? ddram[rd_addr] : CHAR_BLANK;
  end

  always_comb begin
    rd_nib = snap[3:0];
    if (phase == PH_UPPER) rd_nib = e_rise ? live_snap[7:4] : snap[7:4];
  end

  assign oe             = e_s & rw_s;
  assign bus.lcd_db_oe  = oe;
  assign bus.lcd_db_out = oe ? rd_nib : 4'h0;
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder: strobe/error events checked against a queue of expectations.
module tb_lcd_hd44780_responder;
  import lcd_hd44780_pkg::*;

  localparam int CE = 24;
  localparam int CL = 200;
  localparam int EV_STROBE = 0;
  localparam int EV_PERR   = 1;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  lcd_hd44780_responder_if bus();

  logic       busy, disp_on, cursor_on, blink_on, two_line, four_bit_mode, cmd_strobe, protocol_err;
  logic [6:0] ac, rd_addr;
  logic [7:0] rd_data;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int run_len = 0;
  int last_run = 0;
  int ev_obs;
  logic [3:0] wake [4];

  lcd_hd44780_responder #(.CYC_EXEC(CE), .CYC_LONG(CL), .SYNC_STAGES(2)) dut (
    .clk(clk), .nrst(nrst), .bus(bus), .busy(busy), .ac(ac),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .four_bit_mode(four_bit_mode),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .cmd_strobe(cmd_strobe), .protocol_err(protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  always @(negedge clk) begin
    if (cmd_strobe === 1'b1 || protocol_err === 1'b1) begin
      ev_obs = (protocol_err === 1'b1) ? EV_PERR : EV_STROBE;
      if (exp_q.size() == 0) chk("event_unexpected", ev_obs, 9);
      else                   chk("event_order", ev_obs, exp_q.pop_front());
    end
  end

  task automatic pulse(input logic rs, input logic rw, input logic [3:0] nib,
                       output logic [3:0] rd, output logic oe);
    @(posedge clk); #1;
    bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_db_in = nib;
    repeat (2) @(posedge clk); #1;
    bus.lcd_e = 1'b1;
    repeat (6) @(negedge clk);
    rd = bus.lcd_db_out;
    oe = bus.lcd_db_oe;
    @(posedge clk); #1;
    bus.lcd_e = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy === 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("idle", busy, 0);
  endtask

  task automatic wr4(input logic rs, input logic [7:0] b, input logic do_wait);
    logic [3:0] n;
    logic o;
    exp_q.push_back(EV_STROBE);
    pulse(rs, 1'b0, b[7:4], n, o);
    pulse(rs, 1'b0, b[3:0], n, o);
    if (do_wait) wait_idle(CL + 100);
  endtask

  task automatic rd4(input logic rs, output logic [7:0] v, output logic oe);
    logic [3:0] n;
    logic o1, o2;
    pulse(rs, 1'b1, 4'h0, n, o1);
    v[7:4] = n;
    pulse(rs, 1'b1, 4'h0, n, o2);
    v[3:0] = n;
    oe = o1 & o2;
  endtask

  task automatic chk_ram(input logic [6:0] a, input logic [7:0] want);
    rd_addr = a;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk($sformatf("ram[%0d]", a), rd_data, want);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] n;
    logic       o;
    logic [7:0] v;

    wake = '{4'h3, 4'h3, 4'h3, 4'h2};
    bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_db_in = 4'h0;
    rd_addr = 7'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ac", ac, 0);
    chk("rst_4bit", four_bit_mode, 0);
    chk("rst_disp", {disp_on, cursor_on, blink_on, two_line}, 0);
    chk("rst_rd_data", rd_data, 8'h20);
    chk("rst_oe", bus.lcd_db_oe, 0);
    chk("rst_pulses", {cmd_strobe, protocol_err}, 0);
    nrst = 1'b1;
    repeat (2) @(posedge clk);

    // 8-bit wake-up sequence then switch to 4-bit
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(EV_STROBE);
      pulse(1'b0, 1'b0, wake[i], n, o);
      wait_idle(CL + 100);
      chk("wake_busy_len", last_run, CE);
      if (i == 2) chk("still_8bit", four_bit_mode, 0);
    end
    chk("four_bit", four_bit_mode, 1);

    wr4(1'b0, 8'h28, 1'b1);
    chk("two_line", two_line, 1);
    wr4(1'b0, 8'h0F, 1'b1);
    chk("dcb", {disp_on, cursor_on, blink_on}, 3'b111);

    // clear, BF poll while busy and after
    wr4(1'b0, 8'h01, 1'b0);
    rd4(1'b0, v, o);
    chk("bf_busy", v, 8'h80);
    chk("bf_oe", o, 1);
    chk("oe_after", bus.lcd_db_oe, 0);
    wait_idle(CL + 100);
    chk("clear_busy_len", last_run, CL);
    rd4(1'b0, v, o);
    chk("bf_idle", v, 8'h00);
    for (int i = 0; i < 80; i++) chk_ram(7'(i), 8'h20);
    chk_ram(7'd100, 8'h20);
    chk("clear_ac", ac, 0);

    // line-1 end wraps to line 2
    wr4(1'b0, 8'hA7, 1'b1);
    wr4(1'b1, 8'h41, 1'b1);
    chk("ac_wrap_l1", ac, 7'h40);
    wr4(1'b1, 8'h42, 1'b1);
    chk("ac_after_b", ac, 7'h41);
    chk_ram(7'd39, 8'h41);
    chk_ram(7'd40, 8'h42);

    wr4(1'b0, 8'hA7, 1'b1);
    exp_q.push_back(EV_STROBE);
    rd4(1'b1, v, o);
    chk("data_read0", v, 8'h41);
    wait_idle(CL + 100);
    chk("read_busy_len", last_run, CE);
    chk("read_ac_step", ac, 7'h40);
    exp_q.push_back(EV_STROBE);
    rd4(1'b1, v, o);
    chk("data_read1", v, 8'h42);
    wait_idle(CL + 100);
    chk("read_ac_step2", ac, 7'h41);

    // data write issued while busy is dropped
    wr4(1'b0, 8'hC1, 1'b0);
    exp_q.push_back(EV_PERR);
    pulse(1'b1, 1'b0, 4'h5, n, o);
    wait_idle(CL + 100);
    chk("drop_ac", ac, 7'h41);
    chk_ram(7'd41, 8'h20);
    chk_ram(7'd40, 8'h42);

    // decrement wrap line 2 -> line 1
    wr4(1'b0, 8'h04, 1'b1);
    wr4(1'b0, 8'hC0, 1'b1);
    wr4(1'b1, 8'h5A, 1'b1);
    chk("ac_dec_wrap", ac, 7'h27);
    chk_ram(7'd40, 8'h5A);

    // RS mismatch between halves, then recovery with 0x06
    exp_q.push_back(EV_PERR);
    pulse(1'b1, 1'b0, 4'h4, n, o);
    pulse(1'b0, 1'b0, 4'h1, n, o);
    repeat (4) @(negedge clk);
    chk("mismatch_ac", ac, 7'h27);
    wr4(1'b0, 8'h06, 1'b1);
    wr4(1'b0, 8'hC1, 1'b1);
    wr4(1'b1, 8'h33, 1'b1);
    chk("entry_inc", ac, 7'h42);
    chk_ram(7'd41, 8'h33);

    wr4(1'b0, 8'h14, 1'b1);
    chk("shift_right", ac, 7'h43);
    wr4(1'b0, 8'h10, 1'b1);
    chk("shift_left", ac, 7'h42);

    wr4(1'b0, 8'hE7, 1'b1);
    wr4(1'b1, 8'h7E, 1'b1);
    chk("ac_wrap_l2", ac, 7'h00);
    chk_ram(7'd79, 8'h7E);

    wr4(1'b0, 8'hC5, 1'b1);
    wr4(1'b0, 8'h02, 1'b1);
    chk("home_ac", ac, 0);
    chk("home_busy_len", last_run, CL);

    repeat (4) @(negedge clk);
    chk("events_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
